// File: rtl/pipeline_event_monitor.sv
// rtl/pipeline_event_monitor.sv - qualified pipeline event counters over a bounded run window
// Live counters, snapshot shadows, and a muxed read port; all counters saturate with sticky overflow.
module pipeline_event_monitor #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_CYCLES = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic                               clear_i,
  input  logic [NUM_EVENTS-1:0]              event_i,
  input  logic [NUM_EVENTS-1:0]              qual_i,
  input  logic                               snap_i,
  input  logic [$clog2(NUM_EVENTS+1)-1:0]    rd_sel_i,
  output logic [CNT_WIDTH-1:0]               rd_data_o,
  output logic [CNT_WIDTH-1:0]               cycle_o,
  output logic                               running_o,
  output logic                               done_o,
  output logic [NUM_EVENTS:0]                overflow_o
);

  localparam int SEL_W = $clog2(NUM_EVENTS+1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] WINDOW  = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t               state;
  logic                 running;
  logic                 done;
  logic [CNT_WIDTH-1:0] ev_cnt    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] ev_next   [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] ev_shadow [NUM_EVENTS];
  logic [CNT_WIDTH-1:0] cyc_cnt;
  logic [CNT_WIDTH-1:0] cyc_next;
  logic [CNT_WIDTH-1:0] cyc_shadow;
  logic [NUM_EVENTS:0]  ovf;
  logic [NUM_EVENTS:0]  ovf_next;
  logic                 counting;
  logic                 window_hit;

  // An edge counts only while in RUN and start_i is still held; the pause edge is excluded.
  always_comb begin
    counting = (state == RUN) && start_i;
    ovf_next = ovf;
    cyc_next = cyc_cnt;
    if (counting) begin
      if (cyc_cnt == CNT_MAX) ovf_next[NUM_EVENTS] = 1'b1;
      else                    cyc_next = cyc_cnt + ONE;
    end
    for (int k = 0; k < NUM_EVENTS; k++) begin
      ev_next[k] = ev_cnt[k];
      if (counting && event_i[k] && !qual_i[k]) begin
        if (ev_cnt[k] == CNT_MAX) ovf_next[k] = 1'b1;
        else                      ev_next[k] = ev_cnt[k] + ONE;
      end
    end
    window_hit = (MAX_CYCLES != 0) && counting && (cyc_next == WINDOW);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      running    <= 1'b0;
      done       <= 1'b0;
      cyc_cnt    <= '0;
      cyc_shadow <= '0;
      ovf        <= '0;
      for (int k = 0; k < NUM_EVENTS; k++) begin
        ev_cnt[k]    <= '0;
        ev_shadow[k] <= '0;
      end
    end else if (clear_i) begin
      state      <= IDLE;
      running    <= 1'b0;
      done       <= 1'b0;
      cyc_cnt    <= '0;
      cyc_shadow <= '0;
      ovf        <= '0;
      for (int k = 0; k < NUM_EVENTS; k++) begin
        ev_cnt[k]    <= '0;
        ev_shadow[k] <= '0;
      end
    end else begin
      cyc_cnt <= cyc_next;
      ovf     <= ovf_next;
      for (int k = 0; k < NUM_EVENTS; k++) ev_cnt[k] <= ev_next[k];
      // Shadows capture the post-update value so a snap on the final edge sees the full window.
      if (snap_i) begin
        cyc_shadow <= cyc_next;
        for (int k = 0; k < NUM_EVENTS; k++) ev_shadow[k] <= ev_next[k];
      end
      case (state)
        IDLE: if (start_i) begin
          state   <= RUN;
          running <= 1'b1;
        end
        RUN: if (!start_i) begin
          state   <= PAUSE;
          running <= 1'b0;
        end else if (window_hit) begin
          state   <= DONE;
          running <= 1'b0;
          done    <= 1'b1;
        end
        PAUSE: if (start_i) begin
          state   <= RUN;
          running <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_data_o = ev_shadow[k];
    end
    if (rd_sel_i == SEL_W'(NUM_EVENTS)) rd_data_o = cyc_shadow;
  end

  assign cycle_o    = cyc_cnt;
  assign running_o  = running;
  assign done_o     = done;
  assign overflow_o = ovf;

endmodule

// File: doc/pipeline_event_monitor.md
Name: pipeline_event_monitor

Overview:
- Synthesizable, parametrised hardware version of the stall/flush bookkeeping our CPU benches do in simulation.
- Counts NUM_EVENTS qualified pipeline events (stall, flush, and others) plus elapsed cycles over a bounded run window.
- Provides snapshot shadow registers and a muxed read port, so counts are observable on silicon or from any bench.
- Sits beside CPU: event inputs are tapped from the hazard unit, IF_ID flush and the control unit.

Parameters:
- NUM_EVENTS, 4: number of event channels.
- CNT_WIDTH, 32: width of every counter, event and cycle.
- MAX_CYCLES, 64: run-window length in cycles; 0 means unlimited.
- SEL_W, derived localparam, ceil(log2(NUM_EVENTS+1)): select width.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  level run-enable.
- clear_i  in  1  synchronous clear of all counters/flags; returns FSM to IDLE.
- event_i  in  NUM_EVENTS  raw event strobes, one per channel.
- qual_i  in  NUM_EVENTS  per-channel qualifier; an event counts only when event_i[k] & ~qual_i[k] (e.g. stall masked by branch).
- snap_i  in  1  copy live counters into shadow registers.
- rd_sel_i  in  SEL_W  read select: 0..NUM_EVENTS-1 = event shadow k; NUM_EVENTS = cycle shadow.
- rd_data_o  out  CNT_WIDTH  combinational read of the selected shadow; 0 if rd_sel_i > NUM_EVENTS.
- cycle_o  out  CNT_WIDTH  live cycle count.
- running_o  out  1  high in RUN.
- done_o  out  1  high in DONE.
- overflow_o  out  NUM_EVENTS+1  sticky saturation flags; bit NUM_EVENTS belongs to the cycle counter.

Behaviour:
- Reset (async, rst_i=1):
  - FSM to IDLE.
  - All live and shadow counters = 0.
  - overflow_o = 0; running_o = 0; done_o = 0.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: start_i=1 -> RUN. Nothing is counted on the transition edge.
  - RUN, each edge:
    - cycle += 1.
    - For each k: event k += 1 if event_i[k] & ~qual_i[k].
    - start_i=0 -> PAUSE, and that edge does not count.
    - When MAX_CYCLES != 0 and the post-increment cycle == MAX_CYCLES -> DONE. Events sampled on that final edge are counted.
  - PAUSE: all counters hold; start_i=1 -> RUN. The resume edge does not count.
  - DONE: counters frozen; start_i ignored; only clear_i or rst_i leave.
- clear_i:
  - Priority over every other synchronous action.
  - Next edge: live counters, shadows and overflow_o = 0; FSM -> IDLE.
  - snap_i on the same edge is ignored.
- Saturation:
  - A counter at all-ones holds its value.
  - An increment attempt at all-ones sets the matching overflow bit.
  - Overflow bits are sticky until clear_i or rst_i.
  - The cycle counter saturates the same way; this is reachable only with MAX_CYCLES=0.
- Snapshot:
  - snap_i=1 at an edge loads each shadow with the live counter's value after that edge's update.
  - Legal in any state.
  - rd_data_o reflects the new shadow value after the edge, with no extra latency.
- Outputs:
  - cycle_o is the live cycle counter.
  - running_o = (state==RUN); done_o = (state==DONE).
- Widths: counter arithmetic is unsigned CNT_WIDTH; the comparison against MAX_CYCLES uses CNT_WIDTH bits.

Test Plan:
1. Basic run window: MAX_CYCLES=64. Reset, then start_i=1. event_i[0]=1 on 5 RUN cycles, event_i[1]=1 on 2. Expected: after 64 counting edges done_o=1, cycle_o=64; then snap_i, and rd_sel 0/1/4 read 5/2/64.
2. Qualifier masking: event_i[0]=1 for 10 cycles with qual_i[0]=1 on 4 of them -> channel 0 counts 6.
3. Pause/resume: start_i dropped for 7 cycles at cycle 20. Expected: running_o=0 and counts hold for the whole pause; done_o rises 64 counting edges after the start (the pause edge and the resume edge do not count).
4. Saturation: CNT_WIDTH=4, MAX_CYCLES=0, event_i[2] held high. Expected: count sticks at 15; overflow_o[2] rises on the 16th event; 16 counting edges also set overflow_o[4] with cycle_o=15.
5. Clear vs snap collision: clear_i and snap_i together in DONE. Expected: all shadows 0, overflow_o=0, FSM back in IDLE; a following start_i counts from 0.
6. Async reset mid-RUN: rst_i pulse at cycle 30 between clock edges. Expected: all outputs 0 immediately, without waiting for an edge.
